// File: rtl/mskaes_ak_pkg.sv
// rtl/mskaes_ak_pkg.sv - shared types, constants and share-index helper for the masked AddRoundKey block
//
// Purpose : FSM state enum, AES state width, and the (bit, share) -> flat-index mapping
//           used by every sharing in this block (bit b share s lives at b*d+s).
// Ports   : none (package).
package mskaes_ak_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ak_state_e;

    localparam int NBITS = 128;

    // Flat position of bit b, share s in a d-share vector.
    function automatic int sh_idx(input int b, input int s, input int nsh);
        return b * nsh + s;
    endfunction

endpackage

// File: rtl/mskaes_ak_serial_if.sv
// rtl/mskaes_ak_serial_if.sv - handshake/data bundle for mskaes_ak_serial
//
// Purpose : groups the input pair handshake, the result handshake and (optionally) the
//           refresh randomness into one interface.
// Ports   : master (producer/consumer side) drives in_valid, sh_state_in, sh_key_in,
//           out_ready, rnd; slave (the block) drives in_ready, out_valid, sh_state_out.
// Config  : MSKAES_AK_REFRESH_EN adds rnd (W*(d-1) bits).
interface mskaes_ak_serial_if #(
    parameter int d = 2,
    parameter int W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [128*d-1:0]   sh_state_in;
    logic [128*d-1:0]   sh_key_in;
    logic               out_valid;
    logic               out_ready;
    logic [128*d-1:0]   sh_state_out;
`ifdef MSKAES_AK_REFRESH_EN
    logic [W*(d-1)-1:0] rnd;

    modport master (
        output in_valid, sh_state_in, sh_key_in, out_ready, rnd,
        input  in_ready, out_valid, sh_state_out
    );

    modport slave (
        input  in_valid, sh_state_in, sh_key_in, out_ready, rnd,
        output in_ready, out_valid, sh_state_out
    );
`else
    modport master (
        output in_valid, sh_state_in, sh_key_in, out_ready,
        input  in_ready, out_valid, sh_state_out
    );

    modport slave (
        input  in_valid, sh_state_in, sh_key_in, out_ready,
        output in_ready, out_valid, sh_state_out
    );
`endif
endinterface

// File: rtl/mskaes_ak_slice.sv
// rtl/mskaes_ak_slice.sv - combinational W-bit chunk of masked AddRoundKey
//
// Purpose : share-wise XOR of one state chunk with one key chunk; with
//           MSKAES_AK_REFRESH_EN the key chunk is re-shared with fresh randomness first.
// Ports   : st_chunk / key_chunk  in  W*d   chunk bits, local bit j share s at j*d+s
//           rnd                   in  W*(d-1) one W-bit mask per share 0..d-2 (macro only)
//           sum_chunk             out W*d   st_chunk ^ (refreshed) key_chunk
module mskaes_ak_slice #(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic [W*d-1:0]     st_chunk,
    input  logic [W*d-1:0]     key_chunk,
`ifdef MSKAES_AK_REFRESH_EN
    input  logic [W*(d-1)-1:0] rnd,
`endif
    output logic [W*d-1:0]     sum_chunk
);

    logic [W*d-1:0] key_r;

    always_comb begin
        key_r = key_chunk;
`ifdef MSKAES_AK_REFRESH_EN
        // Masks added to shares 0..d-2 are cancelled by their XOR on share d-1,
        // so the unmasked key bit is untouched.
        for (int j = 0; j < W; j++) begin
            logic acc;
            acc = 1'b0;
            for (int s = 0; s < d - 1; s++) begin
                key_r[j*d+s] = key_r[j*d+s] ^ rnd[s*W+j];
                acc          = acc ^ rnd[s*W+j];
            end
            key_r[j*d+d-1] = key_r[j*d+d-1] ^ acc;
        end
`endif
        sum_chunk = st_chunk ^ key_r;
    end

endmodule

// File: rtl/mskaes_ak_serial.sv
// rtl/mskaes_ak_serial.sv - serialised masked AES AddRoundKey over d-share Boolean sharings
//
// Purpose : captures a shared 128-bit state and round key, XORs them share-wise one W-bit
//           chunk per cycle (NCHUNK = 128/W cycles) and holds the shared result until taken.
// Ports   : clk, rst (async, active-high); bus (slave modport of mskaes_ak_serial_if):
//           in_valid/in_ready + sh_state_in/sh_key_in, out_valid/out_ready + sh_state_out,
//           rnd when MSKAES_AK_REFRESH_EN is defined.
// Config  : MSKAES_AK_REFRESH_EN - refresh key shares with rnd before each chunk XOR.
module mskaes_ak_serial
    import mskaes_ak_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mskaes_ak_serial_if.slave bus
);

    localparam int NCHUNK = NBITS / W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHW    = W * d;

    ak_state_e          state;
    logic [CW-1:0]      cnt;
    logic [NBITS*d-1:0] st_q;
    logic [NBITS*d-1:0] key_q;
    logic [CHW-1:0]     chunk_sum;
    int                 base;

    // Because shares of a bit are adjacent, chunk cnt of all shares is one contiguous slice.
    assign base = sh_idx(int'(cnt) * W, 0, d);

    mskaes_ak_slice #(
        .d (d),
        .W (W)
    ) u_slice (
        .st_chunk  (st_q[base +: CHW]),
        .key_chunk (key_q[base +: CHW]),
`ifdef MSKAES_AK_REFRESH_EN
        .rnd       (bus.rnd),
`endif
        .sum_chunk (chunk_sum)
    );

    // rst gates in_ready so nothing is offered acceptance while reset is held.
    assign bus.in_ready     = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign bus.out_valid    = (state == DONE);
    assign bus.sh_state_out = st_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            st_q  <= '0;
            key_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        st_q  <= bus.sh_state_in;
                        key_q <= bus.sh_key_in;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    st_q[base +: CHW] <= chunk_sum;
                    if (cnt == CW'(NCHUNK - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            st_q  <= bus.sh_state_in;
                            key_q <= bus.sh_key_in;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mskaes_ak_serial.sv
// tb/tb_mskaes_ak_serial.sv - self-checking bench for mskaes_ak_serial (d=2/W=32, d=2/W=128, d=3/W=8)
module tb_mskaes_ak_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mskaes_ak_serial_if #(.d(2), .W(32))  if0 ();
    mskaes_ak_serial_if #(.d(2), .W(128)) if1 ();
    mskaes_ak_serial_if #(.d(3), .W(8))   if2 ();

    mskaes_ak_serial #(.d(2), .W(32))  u0 (.clk(clk), .rst(rst), .bus(if0));
    mskaes_ak_serial #(.d(2), .W(128)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mskaes_ak_serial #(.d(3), .W(8))   u2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[4];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [255:0] rconst = {32{8'ha5}};

    task automatic check(input string nm, input logic [383:0] got, input logic [383:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [383:0] mk_share(input logic [127:0] v, input int dd);
        logic [383:0] f = '0;
        for (int b = 0; b < 128; b++) begin
            logic acc = 1'b0;
            for (int s = 0; s < dd - 1; s++) begin
                logic r = 1'($urandom);
                f[b*dd+s] = r;
                acc ^= r;
            end
            f[b*dd+dd-1] = v[b] ^ acc;
        end
        return f;
    endfunction

    function automatic logic [127:0] unmask(input logic [383:0] f, input int dd);
        logic [127:0] v = '0;
        for (int b = 0; b < 128; b++)
            for (int s = 0; s < dd; s++)
                v[b] ^= f[b*dd+s];
        return v;
    endfunction

    // Reference sharing of the result: plain share-wise XOR, plus key refresh with a
    // constant rnd when the refresh build is selected.
    function automatic logic [383:0] model(input logic [383:0] st, input logic [383:0] key,
                                           input logic [255:0] r, input int dd, input int ww);
        logic [383:0] m = '0;
        for (int b = 0; b < 128; b++) begin
            for (int s = 0; s < dd; s++) begin
                logic e = st[b*dd+s] ^ key[b*dd+s];
`ifdef MSKAES_AK_REFRESH_EN
                if (s < dd - 1) e ^= r[s*ww + b%ww];
                else for (int t = 0; t < dd - 1; t++) e ^= r[t*ww + b%ww];
`endif
                m[b*dd+s] = e;
            end
        end
        return m;
    endfunction

    task automatic set_inputs(input logic [383:0] s0, input logic [383:0] k0,
                              input logic [383:0] s1, input logic [383:0] k1,
                              input logic [383:0] s2, input logic [383:0] k2);
        if0.sh_state_in = s0[255:0]; if0.sh_key_in = k0[255:0];
        if1.sh_state_in = s1[255:0]; if1.sh_key_in = k1[255:0];
        if2.sh_state_in = s2;        if2.sh_key_in = k2;
    endtask

    task automatic run_vec(input int idx);
        logic [383:0] s0, k0, s1, k1, s2, k2, o0, o1, o2;
        int lat0 = -1, lat1 = -1, lat2 = -1;
        s0 = mk_share(vt[idx].st, 2); k0 = mk_share(vt[idx].key, 2);
        s1 = mk_share(vt[idx].st, 2); k1 = mk_share(vt[idx].key, 2);
        s2 = mk_share(vt[idx].st, 3); k2 = mk_share(vt[idx].key, 3);
        o0 = '0; o1 = '0; o2 = '0;
        set_inputs(s0, k0, s1, k1, s2, k2);
        if0.in_valid = 1'b1; if1.in_valid = 1'b1; if2.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0; if1.in_valid = 1'b0; if2.in_valid = 1'b0;
        set_inputs(~s0, k0, ~s1, k1, ~s2, ~k2);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (if0.out_valid && lat0 < 0) begin lat0 = k; o0 = {128'b0, if0.sh_state_out}; end
            if (if1.out_valid && lat1 < 0) begin lat1 = k; o1 = {128'b0, if1.sh_state_out}; end
            if (if2.out_valid && lat2 < 0) begin lat2 = k; o2 = if2.sh_state_out; end
        end
        check($sformatf("v%0d_w32_unmask", idx), unmask(o0, 2), vt[idx].exp);
        check($sformatf("v%0d_w32_shares", idx), o0, model(s0, k0, rconst, 2, 32));
        check($sformatf("v%0d_w32_latency", idx), lat0, 4);
        check($sformatf("v%0d_w128_unmask", idx), unmask(o1, 2), vt[idx].exp);
        check($sformatf("v%0d_w128_shares", idx), o1, model(s1, k1, rconst, 2, 128));
        check($sformatf("v%0d_w128_latency", idx), lat1, 1);
        check($sformatf("v%0d_d3w8_unmask", idx), unmask(o2, 3), vt[idx].exp);
        check($sformatf("v%0d_d3w8_shares", idx), o2, model(s2, k2, rconst, 3, 8));
        check($sformatf("v%0d_d3w8_latency", idx), lat2, 16);
    endtask

    initial begin
        logic [383:0] fs, fk, held;
        int perr;
        bit seen;

        vt[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vt[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00102030405060708090a0b0c0d0e0f0};
        vt[2] = '{128'hffffffff00000000ffffffff00000000, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
                  128'hf0f0f0f00f0f0f0ff0f0f0f00f0f0f0f};
        vt[3] = '{{128{1'b1}}, {128{1'b1}}, 128'h0};

        if0.in_valid = 1'b0; if1.in_valid = 1'b0; if2.in_valid = 1'b0;
        if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        set_inputs('0, '0, '0, '0, '0, '0);
`ifdef MSKAES_AK_REFRESH_EN
        if0.rnd = rconst[31:0]; if1.rnd = rconst[127:0]; if2.rnd = rconst[15:0];
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_u0", {if0.in_ready, if0.out_valid, if0.sh_state_out}, '0);
        check("rst_u1", {if1.in_ready, if1.out_valid, if1.sh_state_out}, '0);
        check("rst_u2", {if2.in_ready, if2.out_valid, if2.sh_state_out}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b111);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Back-to-back: results every 5 cycles, in_ready only in DONE
        fs = mk_share(vt[0].st, 2); fk = mk_share(vt[0].key, 2);
        if0.sh_state_in = fs[255:0]; if0.sh_key_in = fk[255:0];
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        perr = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (if0.out_valid !== ((k % 5) == 4)) perr++;
            if (if0.in_ready !== ((k % 5) == 4)) perr++;
            if (if0.out_valid && unmask({128'b0, if0.sh_state_out}, 2) !== vt[0].exp) perr++;
        end
        if0.in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_pattern", perr, 0);
        check("b2b_idle", {if0.in_ready, if0.out_valid}, 2'b10);

        // Backpressure: output held, in_ready low, new offers ignored
        fs = mk_share(vt[0].st, 2); fk = mk_share(vt[0].key, 2);
        if0.sh_state_in = fs[255:0]; if0.sh_key_in = fk[255:0];
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        fs = mk_share(vt[1].st, 2);
        if0.sh_state_in = fs[255:0];
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            seen = if0.out_valid;
        end
        check("bp_seen", seen, 1'b1);
        held = {128'b0, if0.sh_state_out};
        perr = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0) perr++;
            if ({128'b0, if0.sh_state_out} !== held) perr++;
        end
        check("bp_hold", perr, 0);
        check("bp_value", unmask(held, 2), vt[0].exp);
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {if0.in_ready, if0.out_valid}, 2'b10);

        // Reset in BUSY at cnt=2
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {if0.in_ready, if0.out_valid, if0.sh_state_out}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        perr = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) perr++;
            if (if0.sh_state_out !== '0) perr++;
        end
        check("midrst_no_stale", perr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
